// File: rtl/sfm_stream_slicer.sv
// Serialises wide strobed stream beats into OUT_WIDTH-bit slices, skipping empty
// slices, counting emitted slices against a job length and flagging the final one.
module sfm_stream_slicer #(
    parameter int DATA_WIDTH = 128,
    parameter int OUT_WIDTH  = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [LEN_WIDTH-1:0]    tot_len_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [DATA_WIDTH-1:0]   in_data_i,
    input  logic [DATA_WIDTH/8-1:0] in_strb_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [OUT_WIDTH-1:0]    out_data_o,
    output logic [OUT_WIDTH/8-1:0]  out_strb_o,
    output logic                    out_last_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int NS = DATA_WIDTH / OUT_WIDTH;
    localparam int SB = OUT_WIDTH / 8;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    len_q, cnt_q;
    logic                    done_q;
    logic [NS-1:0]           mask_p1;
    logic [DATA_WIDTH-1:0]   data_p1;
    logic [DATA_WIDTH/8-1:0] strb_p1;

    logic [IW-1:0] cur_idx;
    logic          run, pending, one_pending, last, hs, take;

    function automatic logic [IW-1:0] lowest_idx(input logic [NS-1:0] m);
        lowest_idx = '0;
        for (int k = NS - 1; k >= 0; k--) begin
            if (m[k]) lowest_idx = IW'(k);
        end
    endfunction

    function automatic logic [NS-1:0] slice_mask(input logic [DATA_WIDTH/8-1:0] s);
        slice_mask = '0;
        for (int k = 0; k < NS; k++) begin
            slice_mask[k] = |s[k*SB +: SB];
        end
    endfunction

    always_comb begin
        cur_idx     = lowest_idx(mask_p1);
        run         = (state_q == RUN);
        pending     = |mask_p1;
        one_pending = pending && ((mask_p1 & (mask_p1 - 1'b1)) == '0);
        last        = (cnt_q == len_q - 1'b1);
        hs          = run && pending && out_ready_i;
        take        = in_valid_i && in_ready_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i && tot_len_i != '0) state_d = RUN;
            RUN:     if (hs && last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output slice is taken from the registered beat; a beat accepted in cycle t shows up in t+1.
    always_comb begin
        busy_o      = run;
        out_valid_o = run && pending;
        out_last_o  = out_valid_o && last;
        in_ready_o  = run && (!pending || (hs && one_pending && !last));
        done_o      = done_q;
        out_data_o  = '0;
        out_strb_o  = '0;
        if (out_valid_o) begin
            out_data_o = data_p1[cur_idx*OUT_WIDTH +: OUT_WIDTH];
            out_strb_o = strb_p1[cur_idx*SB +: SB];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            len_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            mask_p1 <= '0;
        end else begin
            done_q <= (state_q == IDLE && start_i && tot_len_i == '0) || (hs && last);
            if (state_q == IDLE && start_i) begin
                cnt_q <= '0;
                len_q <= tot_len_i;
            end else if (hs) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // Reaching the job length drops whatever is still pending in the beat.
            if (hs && last) begin
                mask_p1 <= '0;
            end else if (take) begin
                mask_p1 <= slice_mask(in_strb_i);
            end else if (hs) begin
                mask_p1 <= mask_p1 & ~(NS'(1) << cur_idx);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (take) begin
            data_p1 <= in_data_i;
            strb_p1 <= in_strb_i;
        end
    end

endmodule

// File: tb/tb_sfm_stream_slicer.sv
// Directed bench for sfm_stream_slicer with a scoreboard of expected slices.
module tb_sfm_stream_slicer;

    localparam int DW = 128;
    localparam int OW = 32;
    localparam int LW = 16;
    localparam int NS = DW / OW;
    localparam int SB = OW / 8;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            clear_i = 1'b0;
    logic            start_i = 1'b0;
    logic [LW-1:0]   tot_len_i = '0;
    logic            in_valid_i = 1'b0;
    logic            in_ready_o;
    logic [DW-1:0]   in_data_i = '0;
    logic [DW/8-1:0] in_strb_i = '0;
    logic            out_valid_o;
    logic            out_ready_i = 1'b1;
    logic [OW-1:0]   out_data_o;
    logic [SB-1:0]   out_strb_o;
    logic            out_last_o;
    logic            busy_o;
    logic            done_o;

    sfm_stream_slicer #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .LEN_WIDTH(LW)) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
        .tot_len_i(tot_len_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_data_i(in_data_i), .in_strb_i(in_strb_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_strb_o(out_strb_o),
        .out_last_o(out_last_o), .busy_o(busy_o), .done_o(done_o)
    );

    typedef struct packed {
        logic [OW-1:0] d;
        logic [SB-1:0] s;
        logic          l;
    } exp_t;

    exp_t          sb_q[$];
    int            checks = 0;
    int            failures = 0;
    int            job_rem = 0;
    int            cyc = 0;
    logic          tog = 1'b0;
    logic          exp_done = 1'b0;
    logic          stall_prev = 1'b0;
    logic [OW+SB:0] held = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard / protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        logic hs_last;
        hs_last = 1'b0;
        if (stall_prev) begin
            checks++;
            assert (out_valid_o === 1'b1 && {out_data_o, out_strb_o, out_last_o} === held)
            else begin
                failures++;
                $error("FAIL stall_hold observed=%0h/%0b expected=%0h/1",
                       {out_data_o, out_strb_o, out_last_o}, out_valid_o, held);
            end
        end
        if (out_valid_o === 1'b1 && out_ready_i) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $error("FAIL slice_unexpected observed=%0h expected=none",
                       {out_data_o, out_strb_o, out_last_o});
            end else begin
                e = sb_q.pop_front();
                hs_last = e.l;
                assert ({out_data_o, out_strb_o, out_last_o} === e)
                else begin
                    failures++;
                    $error("FAIL slice observed=%0h expected=%0h",
                           {out_data_o, out_strb_o, out_last_o}, e);
                end
            end
        end
        stall_prev = (out_valid_o === 1'b1) && !out_ready_i && !rst_i && !clear_i;
        held = {out_data_o, out_strb_o, out_last_o};
        checks++;
        assert (done_o === exp_done)
        else begin
            failures++;
            $error("FAIL done_pulse observed=%0b expected=%0b", done_o, exp_done);
        end
        exp_done = !rst_i && !clear_i &&
                   (hs_last || (!busy_o && start_i && tot_len_i == '0));
    end

    function automatic logic [DW-1:0] mk(input int b);
        logic [DW-1:0] v;
        for (int k = 0; k < NS; k++) v[k*OW +: OW] = OW'(32'hC0DE_0000 + b * 16 + k);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (tog) out_ready_i = ~out_ready_i;
    endtask

    task automatic start_job(input int len);
        tot_len_i = LW'(len);
        start_i   = 1'b1;
        job_rem   = len;
        tick();
        start_i   = 1'b0;
    endtask

    task automatic push_expected(input logic [DW-1:0] d, input logic [DW/8-1:0] s);
        for (int k = 0; k < NS; k++) begin
            if (|s[k*SB +: SB] && job_rem > 0) begin
                sb_q.push_back('{d: d[k*OW +: OW], s: s[k*SB +: SB], l: (job_rem == 1)});
                job_rem--;
            end
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [DW/8-1:0] s, input bit drop);
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_strb_i  = s;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready_o === 1'b1) begin
                push_expected(d, s);
                tick();
                if (drop) in_valid_i = 1'b0;
                return;
            end
            tick();
        end
        checks++;
        failures++;
        $error("FAIL beat_accept_timeout observed=0 expected=1");
        in_valid_i = 1'b0;
    endtask

    task automatic wait_done(output int at_cyc);
        at_cyc = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                at_cyc = cyc;
                tick();
                return;
            end
            tick();
        end
        checks++;
        failures++;
        $error("FAIL done_timeout observed=0 expected=1");
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid_o), 64'd0);
        chk({tag, "_out_data"}, 64'(out_data_o), 64'd0);
        chk({tag, "_out_strb"}, 64'(out_strb_o), 64'd0);
        chk({tag, "_out_last"}, 64'(out_last_o), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_done"}, 64'(done_o), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready_o), 64'd0);
    endtask

    initial begin
        int t0, td;
        tick();
        tick();
        @(negedge clk);
        chk_idle_outputs("reset");
        tick();
        rst_i = 1'b0;
        tick();

        // T1: two full beats, len 8, no backpressure
        start_job(8);
        t0 = cyc;
        send_beat(mk(0), 16'hFFFF, 1'b0);
        send_beat(mk(1), 16'hFFFF, 1'b1);
        wait_done(td);
        chk("T1_done_latency", 64'(td - t0), 64'd9);
        chk("T1_busy_after", 64'(busy_o), 64'd0);
        chk("T1_in_ready_idle", 64'(in_ready_o), 64'd0);

        // T2: same with out_ready toggling
        out_ready_i = 1'b1;
        tog = 1'b1;
        start_job(8);
        send_beat(mk(0), 16'hFFFF, 1'b0);
        send_beat(mk(1), 16'hFFFF, 1'b1);
        wait_done(td);
        tog = 1'b0;
        out_ready_i = 1'b1;
        chk("T2_drained", 64'(sb_q.size()), 64'd0);

        // T3: sparse strobe skips slices 1 and 3
        start_job(2);
        send_beat(mk(2), 16'h0F0F, 1'b1);
        wait_done(td);
        chk("T3_busy_after", 64'(busy_o), 64'd0);

        // T4: all-zero beat is swallowed
        start_job(4);
        send_beat(mk(3), 16'h0000, 1'b0);
        send_beat(mk(4), 16'hFFFF, 1'b1);
        wait_done(td);
        chk("T4_drained", 64'(sb_q.size()), 64'd0);

        // T5: job ends mid-beat, later beats refused
        start_job(3);
        send_beat(mk(5), 16'hFFFF, 1'b1);
        wait_done(td);
        in_valid_i = 1'b1;
        in_data_i  = mk(6);
        in_strb_i  = 16'hFFFF;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("T5_in_ready_idle", 64'(in_ready_o), 64'd0);
            chk("T5_out_valid_idle", 64'(out_valid_o), 64'd0);
            tick();
        end
        in_valid_i = 1'b0;

        // Zero-length job: done only
        start_job(0);
        t0 = cyc;
        wait_done(td);
        chk("zero_len_done_latency", 64'(td - t0), 64'd0);
        chk("zero_len_busy", 64'(busy_o), 64'd0);

        // T6: reset in the middle of slice 2
        start_job(8);
        send_beat(mk(7), 16'hFFFF, 1'b1);
        tick();
        tick();
        rst_i = 1'b1;
        out_ready_i = 1'b0;
        @(negedge clk);
        chk("T6_slice2_valid", 64'(out_valid_o), 64'd1);
        chk("T6_slice2_data", 64'(out_data_o), 64'(OW'(32'hC0DE_0000 + 7 * 16 + 2)));
        tick();
        rst_i = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk);
        chk_idle_outputs("T6_after_rst");
        sb_q.delete();
        job_rem = 0;
        tick();
        start_job(4);
        send_beat(mk(8), 16'hFFFF, 1'b1);
        wait_done(td);

        // Soft clear mid-job behaves like reset
        start_job(4);
        send_beat(mk(9), 16'hFFFF, 1'b1);
        clear_i = 1'b1;
        out_ready_i = 1'b0;
        tick();
        clear_i = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk);
        chk_idle_outputs("clear");
        sb_q.delete();
        job_rem = 0;
        tick();
        tick();

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
